// File: rtl/cdc_fifo_wptr_full_level.sv
// -----------------------------------------------------------------------------
// cdc_fifo_wptr_full_level
//
// Write-domain pointer and status block of a dual-clock gray-pointer FIFO.
// It is the counterpart of the read-pointer / empty block on the other side
// of the FIFO memory.
//
// Responsibilities:
//   * Bring the read domain's gray read pointer into w_clk through a plain
//     two-flop synchronizer.
//   * Advance the binary write pointer (memory address) and the gray write
//     pointer (handed to the read domain) on every accepted write.
//   * Produce registered full, fill-level and almost-full status, plus a
//     sticky overflow flag for writes attempted while full.
//
// All status is computed from the synchronized read pointer, which can only
// lag the real one. A stale read pointer therefore over-reports the level or
// holds full longer; it never reports free space that does not exist.
//
// Ports:
//   w_clk           in   1              write-domain clock
//   w_rst           in   1              synchronous, active-high reset
//   w_inc           in   1              write request (accepted when !w_full)
//   w_rptr          in   ADDR_SIZE+1    gray read pointer, asynchronous to w_clk
//   w_overflow_clr  in   1              clears w_overflow
//   w_full          out  1              FIFO full (registered)
//   w_ptr           out  ADDR_SIZE+1    gray write pointer (registered)
//   w_addr          out  ADDR_SIZE      binary memory write address
//   w_q2_rptr       out  ADDR_SIZE+1    read pointer after the synchronizer
//   w_level         out  ADDR_SIZE+1    entries as seen by the writer, 0..2**ADDR_SIZE
//   w_almost_full   out  1              registered, w_level >= ALMOST_FULL_THRESH
//   w_overflow      out  1              sticky: write attempted while full
//
// Parameters:
//   ADDR_SIZE           FIFO address width, depth = 2**ADDR_SIZE, must be >= 2
//   ALMOST_FULL_THRESH  almost-full threshold, legal range 1..2**ADDR_SIZE
// -----------------------------------------------------------------------------
module cdc_fifo_wptr_full_level #(
  parameter int ADDR_SIZE          = 4,
  parameter int ALMOST_FULL_THRESH = 2**ADDR_SIZE - 2
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_inc,
  input  logic [ADDR_SIZE:0]   w_rptr,
  input  logic                 w_overflow_clr,
  output logic                 w_full,
  output logic [ADDR_SIZE:0]   w_ptr,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic [ADDR_SIZE:0]   w_q2_rptr,
  output logic [ADDR_SIZE:0]   w_level,
  output logic                 w_almost_full,
  output logic                 w_overflow
);

  // Pointers carry one extra wrap bit so that full (same address, opposite
  // pass) can be told apart from empty (same address, same pass).
  localparam int PW = ADDR_SIZE + 1;

  // Threshold resized to the level width; 2**ADDR_SIZE still fits in PW bits.
  localparam logic [PW-1:0] THRESH = PW'(ALMOST_FULL_THRESH);

  // ---------------------------------------------------------------------------
  // Read-pointer synchronizer
  // ---------------------------------------------------------------------------
  // Nothing may sit between these two flops: the first one is allowed to go
  // metastable and the second one gives it a full cycle to resolve. The read
  // pointer is gray coded, so at most one bit is in flight at any sampling
  // instant and the captured value is either the old or the new pointer.
  logic [PW-1:0] w_q1;

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_q1      <= '0;
      w_q2_rptr <= '0;
    end else begin
      // NOTE: sequential state is assigned with <= so every flop samples the
      // pre-edge value of its source; with = the second stage would copy
      // w_rptr straight through and the synchronizer would collapse.
      w_q1      <= w_rptr;
      w_q2_rptr <= w_q1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer next-state
  // ---------------------------------------------------------------------------
  logic [PW-1:0] w_bin;
  logic          w_accept;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;

  // A rejected write (w_inc while full) leaves both pointers untouched.
  assign w_accept    = w_inc & ~w_full;
  assign w_bin_next  = w_bin + {{ADDR_SIZE{1'b0}}, w_accept};
  assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

  // The memory is addressed with the binary pointer minus its wrap bit.
  assign w_addr = w_bin[ADDR_SIZE-1:0];

  // ---------------------------------------------------------------------------
  // Status next-state
  // ---------------------------------------------------------------------------
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] level_next;
  logic          full_val;
  logic          almost_full_val;

  // Gray to binary: binary bit i is the XOR of all gray bits from i up to
  // the MSB.
  always_comb begin
    // NOTE: every variable written in always_comb receives a default first so
    // no path leaves it unassigned; an unassigned path would infer a latch.
    rbin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_sync[i] = ^(w_q2_rptr >> i);
    end
  end

  // Full: the next write pointer has lapped the synchronized read pointer by
  // exactly one pass. In gray code that means the two top bits differ and
  // all lower bits match. Using the next pointer makes full assert on the
  // same edge that consumes the last free slot.
  assign full_val = (w_gray_next ==
                     {~w_q2_rptr[ADDR_SIZE:ADDR_SIZE-1], w_q2_rptr[ADDR_SIZE-2:0]});

  // Modulo-2**PW subtraction stays correct across the pointer wrap because
  // the two pointers can never be more than 2**ADDR_SIZE apart.
  assign level_next      = w_bin_next - rbin_sync;
  assign almost_full_val = (level_next >= THRESH);

  // ---------------------------------------------------------------------------
  // Pointer and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_bin         <= '0;
      w_ptr         <= '0;
      w_full        <= 1'b0;
      w_level       <= '0;
      w_almost_full <= 1'b0;
    end else begin
      w_bin         <= w_bin_next;
      w_ptr         <= w_gray_next;
      w_full        <= full_val;
      w_level       <= level_next;
      w_almost_full <= almost_full_val;
    end
  end

  // Sticky overflow. The set term is tested first so a rejected write that
  // coincides with a clear request is still recorded.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      w_overflow <= 1'b0;
    end else if (w_inc && w_full) begin
      w_overflow <= 1'b1;
    end else if (w_overflow_clr) begin
      w_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdc_fifo_wptr_full_level.sv
// -----------------------------------------------------------------------------
// tb_cdc_fifo_wptr_full_level
//
// Directed bench for cdc_fifo_wptr_full_level with ADDR_SIZE=4 and
// ALMOST_FULL_THRESH=14. Inputs change 1 ns after a rising edge and outputs
// are sampled at that same point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_cdc_fifo_wptr_full_level;

  localparam int AS = 4;

  logic          w_clk = 1'b0;
  logic          w_rst;
  logic          w_inc;
  logic [AS:0]   w_rptr;
  logic          w_overflow_clr;
  logic          w_full;
  logic [AS:0]   w_ptr;
  logic [AS-1:0] w_addr;
  logic [AS:0]   w_q2_rptr;
  logic [AS:0]   w_level;
  logic          w_almost_full;
  logic          w_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cdc_fifo_wptr_full_level #(
    .ADDR_SIZE          (AS),
    .ALMOST_FULL_THRESH (14)
  ) dut (
    .w_clk          (w_clk),
    .w_rst          (w_rst),
    .w_inc          (w_inc),
    .w_rptr         (w_rptr),
    .w_overflow_clr (w_overflow_clr),
    .w_full         (w_full),
    .w_ptr          (w_ptr),
    .w_addr         (w_addr),
    .w_q2_rptr      (w_q2_rptr),
    .w_level        (w_level),
    .w_almost_full  (w_almost_full),
    .w_overflow     (w_overflow)
  );

  always #5 w_clk = ~w_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle 1 ns before sampling or driving.
  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b);
    return (v >> 1) ^ v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".ptr"},      32'(w_ptr),         32'd0);
    check({tag, ".addr"},     32'(w_addr),        32'd0);
    check({tag, ".q2"},       32'(w_q2_rptr),     32'd0);
    check({tag, ".full"},     32'(w_full),        32'd0);
    check({tag, ".level"},    32'(w_level),       32'd0);
    check({tag, ".afull"},    32'(w_almost_full), 32'd0);
    check({tag, ".overflow"}, 32'(w_overflow),    32'd0);
  endtask

  initial begin
    // ---------------- 1. reset with busy inputs ----------------
    w_rst = 1'b1; w_inc = 1'b1; w_rptr = 5'b10110; w_overflow_clr = 1'b0;
    step();
    check("rst.ptr_edge1", 32'(w_ptr), 32'd0);
    step();
    check_all_zero("rst");

    // ---------------- 2. fill 16 entries ----------------
    w_rst = 1'b0; w_inc = 1'b0; w_rptr = '0;
    step();
    w_inc = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      check($sformatf("fill%0d.level", n), 32'(w_level),       32'(n));
      check($sformatf("fill%0d.afull", n), 32'(w_almost_full), 32'(n >= 14));
      check($sformatf("fill%0d.full",  n), 32'(w_full),        32'(n == 16));
      check($sformatf("fill%0d.addr",  n), 32'(w_addr),        32'(n % 16));
    end
    check("fill.ptr", 32'(w_ptr), 32'b11000);

    // ---------------- 3. overflow ----------------
    step();  // w_inc still high while full
    check("ovf.set.ptr",  32'(w_ptr),      32'b11000);
    check("ovf.set.addr", 32'(w_addr),     32'd0);
    check("ovf.set",      32'(w_overflow), 32'd1);
    check("ovf.set.lvl",  32'(w_level),    32'd16);
    w_inc = 1'b0; w_overflow_clr = 1'b1;
    step();
    check("ovf.clr", 32'(w_overflow), 32'd0);
    w_inc = 1'b1;
    step();
    check("ovf.set_wins", 32'(w_overflow), 32'd1);
    check("ovf.sw.ptr",   32'(w_ptr),      32'b11000);
    w_inc = 1'b0;
    step();
    check("ovf.clr2", 32'(w_overflow), 32'd0);
    w_overflow_clr = 1'b0;

    // ---------------- 4. drain visibility ----------------
    w_rptr = 5'b00110;  // gray(4)
    step();
    check("drain1.q2",   32'(w_q2_rptr), 32'd0);
    check("drain1.full", 32'(w_full),    32'd1);
    check("drain1.lvl",  32'(w_level),   32'd16);
    step();
    check("drain2.q2",    32'(w_q2_rptr),     32'b00110);
    check("drain2.full",  32'(w_full),        32'd1);
    check("drain2.lvl",   32'(w_level),       32'd16);
    check("drain2.afull", 32'(w_almost_full), 32'd1);
    step();
    check("drain3.full",  32'(w_full),        32'd0);
    check("drain3.lvl",   32'(w_level),       32'd12);
    check("drain3.afull", 32'(w_almost_full), 32'd0);

    // ---------------- 5. wrap over 40 writes ----------------
    w_rst = 1'b1; w_rptr = '0;
    step();
    w_rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      // Read side trails the writes already done by three entries.
      w_rptr = gray5((i - 1 > 3) ? i - 4 : 0);
      w_inc  = 1'b1;
      step();
      check($sformatf("wrap%0d.addr", i), 32'(w_addr), 32'(i % 16));
      check($sformatf("wrap%0d.ptr",  i), 32'(w_ptr),  32'(gray5(i)));
      check($sformatf("wrap%0d.full", i), 32'(w_full), 32'd0);
    end
    w_inc  = 1'b0;
    w_rptr = gray5(37);
    for (int i = 0; i < 3; i++) step();
    check("wrap.settle.lvl",   32'(w_level),       32'd3);
    check("wrap.settle.full",  32'(w_full),        32'd0);
    check("wrap.settle.afull", 32'(w_almost_full), 32'd0);
    check("wrap.settle.addr",  32'(w_addr),        32'd8);

    // ---------------- 6. mid-stream reset ----------------
    w_rst = 1'b1; w_rptr = '0;
    step();
    w_rst = 1'b0; w_inc = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("mid.pre.addr",  32'(w_addr),  32'd9);
    check("mid.pre.level", 32'(w_level), 32'd9);
    w_rst = 1'b1;
    step();
    check_all_zero("mid.rst");
    w_rst = 1'b0;
    step();
    check("mid.post.ptr",   32'(w_ptr),   32'b00001);
    check("mid.post.addr",  32'(w_addr),  32'd1);
    check("mid.post.level", 32'(w_level), 32'd1);
    w_inc = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_fifo_wptr_full_level.md
Name: cdc_fifo_wptr_full_level

Overview:
Write-domain pointer and status block for the dual-clock gray-pointer FIFO. It is the counterpart of the read-pointer/empty logic on the other side of the FIFO memory. It synchronizes the read domain's gray read pointer into w_clk, advances the binary and gray write pointers, and generates registered full, fill-level, almost-full and sticky-overflow status for the writer.

Parameters:
ADDR_SIZE, 4, FIFO address width; depth = 2**ADDR_SIZE; must be >= 2.
ALMOST_FULL_THRESH, 2**ADDR_SIZE - 2, w_almost_full asserts when fill level >= this value; legal range 1..2**ADDR_SIZE.

Ports:
w_clk  input  1  write-domain clock
w_rst  input  1  synchronous, active-high reset
w_inc  input  1  write request; accepted only when w_full is 0
w_rptr  input  ADDR_SIZE+1  gray read pointer from the read domain; asynchronous to w_clk
w_overflow_clr  input  1  clears w_overflow
w_full  output  1  FIFO full, registered
w_ptr  output  ADDR_SIZE+1  gray write pointer to the read-domain synchronizer, registered
w_addr  output  ADDR_SIZE  binary memory write address
w_q2_rptr  output  ADDR_SIZE+1  read pointer after the 2-flop synchronizer
w_level  output  ADDR_SIZE+1  entries in the FIFO as seen from the write side, 0..2**ADDR_SIZE
w_almost_full  output  1  registered, w_level >= ALMOST_FULL_THRESH
w_overflow  output  1  sticky: a write was attempted while full

Behaviour:
- Reset (w_rst high at a w_clk edge): w_bin, w_ptr, both sync flops, w_q2_rptr, w_full, w_level, w_almost_full and w_overflow all go to 0. Reset mid-operation discards all state at that edge. Resetting the read side together with this block is a system-level requirement.
- Synchronizer: w_q1 <= w_rptr; w_q2_rptr <= w_q1. There is no other logic between the flops.
- w_accept = w_inc & ~w_full.
- w_bin_next = w_bin + w_accept, modulo 2**(ADDR_SIZE+1).
- w_gray_next = (w_bin_next >> 1) ^ w_bin_next.
- Each edge: w_bin <= w_bin_next; w_ptr <= w_gray_next.
- w_addr = w_bin[ADDR_SIZE-1:0] (binary, combinational from the register).
- Full:
  - full_val = (w_gray_next == {~w_q2_rptr[ADDR_SIZE:ADDR_SIZE-1], w_q2_rptr[ADDR_SIZE-2:0]}).
  - w_full <= full_val.
  - Full asserts on the same edge that accepts the last free slot.
- Level:
  - rbin_sync = gray-to-binary(w_q2_rptr), combinational XOR-prefix from the MSB.
  - w_level <= (w_bin_next - rbin_sync), modulo 2**(ADDR_SIZE+1).
  - Invariant: w_level == 2**ADDR_SIZE exactly when w_full == 1.
- Almost full: w_almost_full <= (level_next >= ALMOST_FULL_THRESH), where level_next is the unregistered level value.
- Overflow:
  - Set when w_inc & w_full at an edge; cleared by w_overflow_clr.
  - If set and clear occur at the same edge, set wins.
  - A rejected write never changes w_bin or w_ptr.
- Latency:
  - Write accepted at edge k: w_ptr, w_addr, w_full, w_level and w_almost_full all reflect it after edge k.
  - Change on w_rptr: visible in w_q2_rptr after 2 edges; visible in w_full, w_level and w_almost_full after 3 edges.
- Status is pessimistic: a stale read pointer can only over-report the level or hold full longer. It never reports free space that does not exist.
- Wrap-around: pointer MSB toggles on each pass through the memory. w_addr wraps from 2**ADDR_SIZE-1 to 0. Level arithmetic stays correct across the 2**(ADDR_SIZE+1) wrap.

Test Plan:
1. Reset: hold w_rst 2 edges with w_inc=1 and w_rptr=5'b10110 -> all outputs 0; w_ptr stays 0 during reset.
2. Fill (ADDR_SIZE=4, THRESH=14), w_rptr=0, 16 consecutive w_inc:
   - w_almost_full rises after the 14th write (w_level=14).
   - w_full and w_level=16 after the 16th write.
   - w_ptr=5'b11000, w_addr=0.
3. Overflow: while full, pulse w_inc -> w_ptr unchanged, w_overflow=1 next edge.
   - w_overflow_clr alone -> 0.
   - w_inc and w_overflow_clr together while full -> w_overflow stays 1.
4. Drain visibility: while full, step w_rptr to gray(4)=5'b00110 -> w_q2_rptr updates after 2 edges.
   - w_full=0, w_level=12 and w_almost_full=0 exactly 3 edges after the change; unchanged before that.
5. Wrap: 40 writes, with the bench stepping w_rptr (gray) to track writes minus 3 -> w_addr wraps 15->0 twice; w_ptr MSB toggles at binary 16 and 32.
   - w_level settles at 3 once w_rptr stops changing; w_full never asserts.
6. Mid-stream reset: after 9 writes, assert w_rst for 1 edge concurrent with w_inc=1 -> all outputs 0 after that edge.
   - Next accepted write gives w_ptr=5'b00001 and w_addr=1.
